// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM handshake states, data word, and the
// RAM arbiter's sequencing states.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    WORD0,
    WORD1,
    ABORT
  } ram_arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first active index at or after rr_ptr_i,
// wrapping modulo NREQ.
module rr_picker #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         active_i,
  input  logic [$clog2(NREQ)-1:0] rr_ptr_i,
  output logic [$clog2(NREQ)-1:0] winner_o,
  output logic                    any_active_o
);

  localparam int unsigned IdW = $clog2(NREQ);

  always_comb begin
    winner_o     = '0;
    any_active_o = 1'b0;
    // Scan from the farthest offset down so the nearest active index wins.
    for (int i = NREQ - 1; i >= 0; i--) begin
      int idx;
      idx = (int'(rr_ptr_i) + i) % NREQ;
      if (active_i[idx]) begin
        winner_o     = IdW'(idx);
        any_active_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter for the shared RAM port: single/two-word transfers,
// per-requester wait/err, and a per-word watchdog.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREQ-1:0]         req_ren,
  input  logic [NREQ-1:0]         req_wen,
  input  logic [NREQ-1:0]         req_burst,
  input  logic [NREQ*32-1:0]      req_addr,
  input  logic [NREQ*32-1:0]      req_store,
  output logic [NREQ-1:0]         req_wait,
  output logic [NREQ-1:0]         req_err,
  output word_t                   req_load,
  output logic                    grant_valid,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    ramREN,
  output logic                    ramWEN,
  output word_t                   ramaddr,
  output word_t                   ramstore,
  input  word_t                   ramload,
  input  ramstate_t               ramstate
);

  localparam int unsigned IdW = $clog2(NREQ);
  localparam int unsigned TW  = $clog2(TIMEOUT) + 1;

  ram_arb_state_t state_q, state_d;
  logic [IdW-1:0] owner_q, owner_d;
  logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
  logic           burst_q, burst_d;
  logic [TW-1:0]  timer_q, timer_d;

  logic [IdW-1:0] winner;
  logic           any_active;
  logic [IdW-1:0] next_ptr;
  logic           own_ren, own_wen, dropped;
  word_t          own_addr, own_store;

  rr_picker #(
    .NREQ(NREQ)
  ) u_rr_picker (
    .active_i    (req_ren | req_wen),
    .rr_ptr_i    (rr_ptr_q),
    .winner_o    (winner),
    .any_active_o(any_active)
  );

  assign own_ren   = req_ren[owner_q];
  assign own_wen   = req_wen[owner_q];
  assign own_addr  = req_addr[int'(owner_q)*32 +: 32];
  assign own_store = req_store[int'(owner_q)*32 +: 32];
  assign dropped   = ~(own_ren | own_wen);
  assign next_ptr  = (owner_q == IdW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  assign req_load    = ramload;
  assign grant_valid = (state_q != IDLE);
  assign grant_id    = owner_q;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    burst_d  = burst_q;
    timer_d  = timer_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    req_wait = '1;
    req_err  = '0;

    case (state_q)
      IDLE: begin
        if (any_active) begin
          owner_d = winner;
          burst_d = req_burst[winner];
          timer_d = '0;
          state_d = WORD0;
        end
      end
      WORD0, WORD1: begin
        if (dropped) begin
          // Owner withdrew: release the port without advancing the pointer.
          state_d = IDLE;
        end else begin
          ramWEN   = own_wen;
          ramREN   = own_ren & ~own_wen;
          ramstore = own_store;
          if (state_q == WORD1) begin
            ramaddr = {own_addr[31:3], 3'b100};
          end else begin
            ramaddr = burst_q ? {own_addr[31:3], 3'b000} : own_addr;
          end
          if (ramstate == ERROR) begin
            state_d = ABORT;
          end else if (ramstate == ACCESS) begin
            req_wait[owner_q] = 1'b0;
            if (state_q == WORD0 && burst_q) begin
              state_d = WORD1;
              timer_d = '0;
            end else begin
              state_d  = IDLE;
              rr_ptr_d = next_ptr;
            end
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            state_d = ABORT;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      ABORT: begin
        req_err[owner_q] = 1'b1;
        state_d          = IDLE;
        rr_ptr_d         = next_ptr;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      burst_q  <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      burst_q  <= burst_d;
      timer_q  <= timer_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed testbench for ram_arbiter with NREQ=4, TIMEOUT=64.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  req_ren, req_wen, req_burst;
  logic [127:0] req_addr, req_store;
  logic [3:0]  req_wait, req_err;
  word_t       req_load;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic        ramREN, ramWEN;
  word_t       ramaddr, ramstore, ramload;
  ramstate_t   ramstate;

  int checks = 0;
  int errors = 0;

  ram_arbiter #(
    .NREQ   (4),
    .TIMEOUT(64)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_ren    (req_ren),
    .req_wen    (req_wen),
    .req_burst  (req_burst),
    .req_addr   (req_addr),
    .req_store  (req_store),
    .req_wait   (req_wait),
    .req_err    (req_err),
    .req_load   (req_load),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .ramREN     (ramREN),
    .ramWEN     (ramWEN),
    .ramaddr    (ramaddr),
    .ramstore   (ramstore),
    .ramload    (ramload),
    .ramstate   (ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_reqs();
    req_ren   = '0;
    req_wen   = '0;
    req_burst = '0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    clear_reqs();
    req_addr = '0; req_store = '0; ramload = '0; ramstate = FREE;
    tick(); tick();
    checks++; if (req_wait !== 4'hF) begin errors++; $display("FAIL rst_wait got=%h exp=f", req_wait); end
    checks++; if (req_err !== 4'h0) begin errors++; $display("FAIL rst_err got=%h exp=0", req_err); end
    checks++; if ({ramREN, ramWEN, grant_valid} !== 3'b000) begin errors++; $display("FAIL rst_en got=%b exp=000", {ramREN, ramWEN, grant_valid}); end
    checks++; if ({ramaddr, ramstore} !== 64'h0) begin errors++; $display("FAIL rst_bus got=%h exp=0", {ramaddr, ramstore}); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_id got=%0d exp=0", grant_id); end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    req_ren = 4'b0100; req_addr[2*32 +: 32] = 32'h100; ramstate = BUSY;
    #1;
    checks++; if ({ramREN, grant_valid} !== 2'b00) begin errors++; $display("FAIL rd_idle got=%b exp=00", {ramREN, grant_valid}); end
    tick();
    checks++; if ({grant_valid, grant_id} !== 3'b110) begin errors++; $display("FAIL rd_grant got=%b exp=110", {grant_valid, grant_id}); end
    checks++; if ({ramREN, ramWEN} !== 2'b10) begin errors++; $display("FAIL rd_en got=%b exp=10", {ramREN, ramWEN}); end
    checks++; if (ramaddr !== 32'h100) begin errors++; $display("FAIL rd_addr got=%h exp=100", ramaddr); end
    checks++; if (req_wait !== 4'hF) begin errors++; $display("FAIL rd_busywait got=%h exp=f", req_wait); end
    tick();
    ramstate = ACCESS; ramload = 32'hDEAD_BEEF;
    #1;
    checks++; if (req_wait !== 4'b1011) begin errors++; $display("FAIL rd_wait got=%h exp=b", req_wait); end
    checks++; if (req_load !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_load got=%h exp=deadbeef", req_load); end
    tick();
    // rr_ptr should now be 3: all-active must pick requester 3.
    ramstate = BUSY; req_ren = 4'b1111;
    #1;
    checks++; if ({grant_valid, req_wait} !== 5'b01111) begin errors++; $display("FAIL rd_done got=%b exp=01111", {grant_valid, req_wait}); end
    tick();
    checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL rd_ptr got=%0d exp=3", grant_id); end
    clear_reqs();
    #1;
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL drop0_en got=%b exp=0", ramREN); end
    tick();
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL drop0_idle got=%b exp=0", grant_valid); end
  endtask

  task automatic test_burst_write();
    // rr_ptr still 3 (drop did not advance it).
    req_wen = 4'b0010; req_burst = 4'b0010;
    req_addr[1*32 +: 32] = 32'h204; req_store[1*32 +: 32] = 32'hA5A5_0001;
    tick();
    checks++; if ({ramWEN, ramREN, grant_id} !== 4'b1001) begin errors++; $display("FAIL bw_en0 got=%b exp=1001", {ramWEN, ramREN, grant_id}); end
    checks++; if (ramaddr !== 32'h200) begin errors++; $display("FAIL bw_addr0 got=%h exp=200", ramaddr); end
    checks++; if (ramstore !== 32'hA5A5_0001) begin errors++; $display("FAIL bw_store0 got=%h exp=a5a50001", ramstore); end
    ramstate = ACCESS;
    #1;
    checks++; if (req_wait !== 4'b1101) begin errors++; $display("FAIL bw_wait0 got=%h exp=d", req_wait); end
    tick();
    req_store[1*32 +: 32] = 32'hA5A5_0002;
    #1;
    checks++; if ({ramWEN, ramaddr} !== {1'b1, 32'h204}) begin errors++; $display("FAIL bw_addr1 got=%b/%h exp=1/204", ramWEN, ramaddr); end
    checks++; if (ramstore !== 32'hA5A5_0002) begin errors++; $display("FAIL bw_store1 got=%h exp=a5a50002", ramstore); end
    checks++; if (req_wait !== 4'b1101) begin errors++; $display("FAIL bw_wait1 got=%h exp=d", req_wait); end
    tick();
    checks++; if ({grant_valid, ramWEN} !== 2'b00) begin errors++; $display("FAIL bw_idle got=%b exp=00", {grant_valid, ramWEN}); end
    clear_reqs();
    tick();
  endtask

  task automatic test_fairness();
    logic [1:0] exp_id [5];
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    #1; RST = 1'b1; #1; RST = 1'b0;
    req_ren = 4'b1111; ramstate = ACCESS;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (grant_id !== exp_id[k] || grant_valid !== 1'b1) begin errors++; $display("FAIL fair_%0d got=%0d exp=%0d", k, grant_id, exp_id[k]); end
      checks++; if (req_wait !== ~(4'b0001 << exp_id[k])) begin errors++; $display("FAIL fair_wait_%0d got=%h exp=%h", k, req_wait, ~(4'b0001 << exp_id[k])); end
      tick();
    end
    clear_reqs();
  endtask

  task automatic test_read_write_same();
    req_ren = 4'b0001; req_wen = 4'b0001; ramstate = BUSY;
    tick();
    checks++; if ({ramWEN, ramREN, grant_id} !== 4'b1000) begin errors++; $display("FAIL rw_en got=%b exp=1000", {ramWEN, ramREN, grant_id}); end
    clear_reqs();
    tick();
  endtask

  task automatic test_timeout();
    // rr_ptr=1: among {0,2}, requester 2 wins first.
    req_ren = 4'b0101; ramstate = BUSY;
    tick();
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL to_grant got=%0d exp=2", grant_id); end
    for (int k = 0; k < 63; k++) tick();
    checks++; if ({req_err, ramREN} !== 5'b00001) begin errors++; $display("FAIL to_last got=%b exp=00001", {req_err, ramREN}); end
    tick();
    checks++; if (req_err !== 4'b0100) begin errors++; $display("FAIL to_err got=%h exp=4", req_err); end
    checks++; if ({req_wait, ramREN, grant_valid} !== 6'b111101) begin errors++; $display("FAIL to_abort got=%b exp=111101", {req_wait, ramREN, grant_valid}); end
    tick();
    checks++; if ({req_err, grant_valid} !== 5'b00000) begin errors++; $display("FAIL to_idle got=%b exp=00000", {req_err, grant_valid}); end
    tick();
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL to_next got=%0d exp=0", grant_id); end
    ramstate = ERROR;
    tick();
    checks++; if (req_err !== 4'b0001) begin errors++; $display("FAIL er_err got=%h exp=1", req_err); end
    clear_reqs(); ramstate = BUSY;
    tick();
    checks++; if (req_err !== 4'b0000) begin errors++; $display("FAIL er_pulse got=%h exp=0", req_err); end
  endtask

  task automatic test_drop_word1();
    // rr_ptr=1 after the ERROR abort of requester 0.
    req_ren = 4'b0010; req_burst = 4'b0010; req_addr[1*32 +: 32] = 32'h20C; ramstate = ACCESS;
    tick();
    checks++; if (ramaddr !== 32'h208) begin errors++; $display("FAIL dr_addr0 got=%h exp=208", ramaddr); end
    tick();
    checks++; if (ramaddr !== 32'h20C) begin errors++; $display("FAIL dr_addr1 got=%h exp=20c", ramaddr); end
    req_ren = 4'b0000;
    #1;
    checks++; if ({ramREN, req_wait} !== 5'b01111) begin errors++; $display("FAIL dr_en got=%b exp=01111", {ramREN, req_wait}); end
    tick();
    checks++; if ({grant_valid, req_err} !== 5'b00000) begin errors++; $display("FAIL dr_idle got=%b exp=00000", {grant_valid, req_err}); end
    req_ren = 4'b1010; req_burst = 4'b0000;
    tick();
    checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL dr_ptr got=%0d exp=1", grant_id); end
    clear_reqs();
    tick();
  endtask

  task automatic test_reset_mid();
    req_wen = 4'b1000; req_addr[3*32 +: 32] = 32'h300; ramstate = BUSY;
    tick();
    checks++; if ({ramWEN, grant_id, ramaddr} !== {1'b1, 2'd3, 32'h300}) begin errors++; $display("FAIL rm_pre got=%b/%0d/%h exp=1/3/300", ramWEN, grant_id, ramaddr); end
    #1; RST = 1'b1; #1;
    checks++; if ({ramWEN, ramREN, grant_valid, grant_id} !== 5'b00000) begin errors++; $display("FAIL rm_en got=%b exp=00000", {ramWEN, ramREN, grant_valid, grant_id}); end
    checks++; if ({req_wait, req_err, ramaddr} !== {4'hF, 4'h0, 32'h0}) begin errors++; $display("FAIL rm_out got=%h/%h/%h exp=f/0/0", req_wait, req_err, ramaddr); end
    clear_reqs();
    #1; RST = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_burst_write();
    test_fairness();
    test_read_write_same();
    test_timeout();
    test_drop_word1();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Round-robin arbiter sharing the single RAM port among NREQ requesters (I-cache and D-cache ports of both cores, coherence write-back path).
- Sequences single-word or two-word (block) transfers, generates per-requester wait/load, and enforces a watchdog timeout on the RAM.
- Sits between requester fronts and ram.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 64, max cycles per word without ramstate==ACCESS before abort.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- req_ren  in  NREQ  read request per requester.
- req_wen  in  NREQ  write request per requester; wins over req_ren if both set.
- req_burst  in  NREQ  1 = two-word block transfer, 0 = single word.
- req_addr  in  NREQ x 32  byte address.
- req_store  in  NREQ x 32  write data, sampled per word.
- req_wait  out  NREQ  1 = not done; low exactly on the completing ACCESS cycle of each word.
- req_err  out  NREQ  one-cycle abort pulse to the owner.
- req_load  out  32  ramload broadcast; valid for the owner when its req_wait is low.
- grant_valid  out  1  transfer in progress.
- grant_id  out  $clog2(NREQ)  current owner.
- ramREN, ramWEN  out  1  RAM enables.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR.

Behaviour:
- Reset values:
  - State IDLE, owner=0, rr_ptr=0, timer=0.
  - All req_wait=1, req_err=0, ramREN=ramWEN=0, ramaddr=ramstore=0, grant_valid=0, grant_id=0.
- States: IDLE, WORD0, WORD1, ABORT.
- IDLE:
  - No RAM enables driven.
  - Active requester = ren|wen.
  - Winner = first active index scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - Register owner and the owner's burst bit; go to WORD0; timer cleared.
  - Minimum latency: request in cycle 0, RAM enables asserted in cycle 1.
- WORD0:
  - ramWEN=wen[owner], ramREN=ren[owner]&!wen[owner].
  - ramaddr = burst ? {addr[31:3],3'b000} : addr.
  - ramstore = store[owner].
  - On ACCESS: req_wait[owner]=0 combinationally. If burst, go to WORD1 with timer cleared; else go to IDLE with rr_ptr=(owner+1) mod NREQ.
- WORD1:
  - Same as WORD0 but ramaddr={addr[31:3],3'b100}.
  - On ACCESS: req_wait[owner]=0, go to IDLE, advance rr_ptr.
- Timer: increments every WORD0/WORD1 cycle that is not ACCESS. At timer==TIMEOUT-1 without ACCESS, or on ramstate==ERROR, go to ABORT.
- ABORT (1 cycle):
  - req_err[owner]=1, req_wait[owner] stays 1, no RAM enables.
  - Go to IDLE and advance rr_ptr.
- Owner drops both ren and wen in WORD0/WORD1:
  - RAM enables deassert that cycle (combinational from request).
  - Go to IDLE; rr_ptr not advanced; no req_err.
- Non-owner req_wait stays 1 throughout; non-owner requests are held, never lost.
- rr_ptr wraps NREQ-1 -> 0.
- A completed requester re-requesting in the next IDLE loses to any other active requester.
- ren/wen/burst/addr changing mid-transfer is a protocol violation. Exception: the drop case above. Addr[31:3] is re-read every cycle; no internal latch beyond owner and burst.
- grant_valid=1 in WORD0/WORD1/ABORT; grant_id=owner.
- RST asserted mid-transfer: immediately back to reset values; RAM enables drop asynchronously.

Decomposition:
- cpu_types_pkg: ramstate_t and word_t (existing).
- Add ram_arb_state_t {IDLE, WORD0, WORD1, ABORT} to the same package.
- One sub-module: rr_picker (combinational). Inputs: active vector, rr_ptr. Outputs: winner index, any_active.

Test Plan:
- Single read: req_ren[2]=1, addr=0x100, RAM ACCESS on 2nd cycle. Expect: ramaddr=0x100, req_load=ramload, req_wait[2] low one cycle, rr_ptr->3.
- Burst write: req_wen[1]=1, burst=1, addr=0x204. Expect: ramaddr 0x200 then 0x204, ramWEN=1 both words, two wait-low pulses, then IDLE.
- Fairness: all four requesters hold single reads, rr_ptr=0. Expect: grant order 0,1,2,3,0; no requester granted twice before all others are served.
- Read+write same requester: ren[0]=wen[0]=1. Expect: ramWEN=1, ramREN=0.
- Timeout: ramstate stuck BUSY. Expect: ABORT after 64 cycles, req_err[owner] one-cycle pulse, next requester granted. Repeat with ramstate=ERROR: ABORT next cycle.
- Drop and reset: owner drops request in WORD1 -> IDLE, rr_ptr unchanged. Separately, RST pulsed during WORD0 -> all outputs at reset values that cycle.
